// File: rtl/mtl2_cpu_oci_itrace_packer.sv
// Nios II OCI instruction-trace packer: packs 2-bit retire codes into a 15-slot
// buffer and emits DCT/ADDR/STOP packets through a 2-entry valid/ready queue.
module mtl2_cpu_oci_itrace_packer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        trc_on_i,
    input  logic        inst_retire_i,
    input  logic [1:0]  inst_code_i,
    input  logic [31:0] inst_target_i,
    input  logic        itm_ready_i,
    output logic        itm_valid_o,
    output logic [37:0] itm_o,
    output logic [29:0] dct_buffer_o,
    output logic [3:0]  dct_count_o,
    output logic        overflow_o
);

    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  occ_q, occ_d;
    logic [37:0] q0_q, q0_d, q1_q, q1_d;

    logic        pop;
    logic [1:0]  free;
    logic [1:0]  rem;
    logic [1:0]  push_n;
    logic [37:0] pkt_a, pkt_b;
    logic [29:0] nb;
    logic [3:0]  nc;

    always_comb begin
        pop    = (occ_q != 2'd0) && itm_ready_i;
        // A pop in this cycle frees its slot for a same-cycle push.
        free   = 2'd2 - occ_q + {1'b0, pop};
        rem    = occ_q - {1'b0, pop};
        nb     = {buf_q[27:0], inst_code_i};
        nc     = cnt_q + 4'd1;

        buf_d  = buf_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        push_n = 2'd0;
        pkt_a  = '0;
        pkt_b  = '0;

        if (!trc_on_i && occ_q == 2'd0) begin
            ovf_d = 1'b0;
        end

        if (trc_on_i && inst_retire_i) begin
            if (inst_code_i == 2'b11) begin
                if (free >= 2'd2) begin
                    push_n = 2'd2;
                    pkt_a  = {4'h1, nc, nb};
                    pkt_b  = {4'h3, 2'b00, inst_target_i};
                    buf_d  = '0;
                    cnt_d  = '0;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (nc == 4'd15) begin
                if (free >= 2'd1) begin
                    push_n = 2'd1;
                    pkt_a  = {4'h1, nc, nb};
                    buf_d  = '0;
                    cnt_d  = '0;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                buf_d = nb;
                cnt_d = nc;
            end
        end else if (!trc_on_i && cnt_q != 4'd0 && free != 2'd0) begin
            push_n = 2'd1;
            pkt_a  = {4'h1, cnt_q, buf_q};
            buf_d  = '0;
            cnt_d  = '0;
        end

        q0_d = pop ? q1_q : q0_q;
        q1_d = q1_q;
        // Pushes land after whatever survives the pop; rem + push_n never exceeds 2.
        if (push_n != 2'd0) begin
            if (rem == 2'd0) begin
                q0_d = pkt_a;
            end else begin
                q1_d = pkt_a;
            end
        end
        if (push_n == 2'd2) begin
            q1_d = pkt_b;
        end
        occ_d = rem + push_n;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            occ_q <= 2'd0;
            q0_q  <= '0;
            q1_q  <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            occ_q <= occ_d;
            q0_q  <= q0_d;
            q1_q  <= q1_d;
        end
    end

    assign itm_valid_o  = (occ_q != 2'd0);
    assign itm_o        = itm_valid_o ? q0_q : 38'd0;
    assign dct_buffer_o = buf_q;
    assign dct_count_o  = cnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_mtl2_cpu_oci_itrace_packer.sv
// Directed self-checking bench for the OCI instruction-trace packer.
module tb_mtl2_cpu_oci_itrace_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trc_on;
    logic        inst_retire;
    logic [1:0]  inst_code;
    logic [31:0] inst_target;
    logic        itm_ready;
    logic        itm_valid;
    logic [37:0] itm;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    mtl2_cpu_oci_itrace_packer u_dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .trc_on_i     (trc_on),
        .inst_retire_i(inst_retire),
        .inst_code_i  (inst_code),
        .inst_target_i(inst_target),
        .itm_ready_i  (itm_ready),
        .itm_valid_o  (itm_valid),
        .itm_o        (itm),
        .dct_buffer_o (dct_buffer),
        .dct_count_o  (dct_count),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [1:0] code, input logic [31:0] tgt);
        inst_retire = 1'b1;
        inst_code   = code;
        inst_target = tgt;
        tick();
        inst_retire = 1'b0;
        inst_code   = 2'b00;
        inst_target = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; trc_on = 1'b0; inst_retire = 1'b0; inst_code = 2'b00;
        inst_target = '0; itm_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", itm_valid, 0);
        check("rst_itm", itm, 0);
        check("rst_count", dct_count, 0);
        check("rst_buffer", dct_buffer, 0);
        check("rst_ovf", overflow, 0);

        // 15 sequential retires -> one full-buffer DCT packet
        trc_on = 1'b1; itm_ready = 1'b1;
        for (int i = 0; i < 14; i++) retire(2'b00, '0);
        check("t1_count14", dct_count, 14);
        check("t1_novalid", itm_valid, 0);
        retire(2'b00, '0);
        check("t1_valid", itm_valid, 1);
        check("t1_itm", itm, 38'h7C0000000);
        check("t1_count0", dct_count, 0);
        tick();
        check("t1_single", itm_valid, 0);

        // 10, 01, then indirect
        retire(2'b10, '0);
        retire(2'b01, '0);
        check("t2_buf", dct_buffer, 30'h9);
        check("t2_cnt", dct_count, 2);
        retire(2'b11, 32'h0000_1234);
        check("t2_dct", itm, 38'h4C0000027);
        check("t2_buf0", dct_buffer, 0);
        check("t2_cnt0", dct_count, 0);
        tick();
        check("t2_addr", itm, 38'hC00001234);
        check("t2_addr_v", itm_valid, 1);
        tick();
        check("t2_empty", itm_valid, 0);

        // Fill queue while stalled, then drop an indirect
        itm_ready = 1'b0;
        for (int i = 0; i < 30; i++) retire(2'b00, '0);
        check("t3_valid", itm_valid, 1);
        check("t3_noovf", overflow, 0);
        retire(2'b11, 32'hDEAD_BEEF);
        check("t3_ovf", overflow, 1);
        check("t3_cnt", dct_count, 0);
        check("t3_itm", itm, 38'h7C0000000);
        // Code 00 past 14 also needs a slot: a 15-slot buffer against a full queue drops
        for (int i = 0; i < 14; i++) retire(2'b00, '0);
        retire(2'b00, '0);
        check("t3_drop15", dct_count, 14);

        // Drain, then STOP flush; overflow clears once the queue is empty
        do_reset();
        trc_on = 1'b1; itm_ready = 1'b0;
        for (int i = 0; i < 30; i++) retire(2'b00, '0);
        retire(2'b11, 32'h1);
        check("t4_ovf_set", overflow, 1);
        itm_ready = 1'b1;
        tick(); tick();
        check("t4_drained", itm_valid, 0);
        check("t4_ovf_held", overflow, 1);
        for (int i = 0; i < 3; i++) retire(2'b01, '0);
        trc_on = 1'b0;
        tick();
        check("t4_stop", itm, 38'h4C0000015);
        check("t4_cnt0", dct_count, 0);
        check("t4_ovf_clr", overflow, 0);
        tick();
        check("t4_empty", itm_valid, 0);

        // Reset mid-operation
        trc_on = 1'b1; itm_ready = 1'b0;
        for (int i = 0; i < 30; i++) retire(2'b00, '0);
        for (int i = 0; i < 7; i++) retire(2'b01, '0);
        retire(2'b11, 32'h5);
        check("t5_cnt7", dct_count, 7);
        check("t5_ovf", overflow, 1);
        do_reset();
        check("t5_valid", itm_valid, 0);
        check("t5_itm", itm, 0);
        check("t5_cnt", dct_count, 0);
        check("t5_ovf0", overflow, 0);

        // Full queue, pop and 15th retire in the same cycle
        trc_on = 1'b1; itm_ready = 1'b0;
        for (int i = 0; i < 30; i++) retire(2'b00, '0);
        for (int i = 0; i < 14; i++) retire(2'b10, '0);
        itm_ready = 1'b1;
        retire(2'b00, '0);
        itm_ready = 1'b0;
        check("t6_valid", itm_valid, 1);
        check("t6_ovf", overflow, 0);
        check("t6_cnt", dct_count, 0);
        check("t6_head", itm, 38'h7C0000000);
        itm_ready = 1'b1;
        tick();
        check("t6_new", itm, 38'h7EAAAAAA8);
        tick();
        check("t6_empty", itm_valid, 0);

        // Two pushes against a full queue with one pop: 1 free is not enough
        itm_ready = 1'b0;
        for (int i = 0; i < 30; i++) retire(2'b00, '0);
        retire(2'b01, '0);
        itm_ready = 1'b1;
        retire(2'b11, 32'hABCD);
        itm_ready = 1'b0;
        check("t7_ovf", overflow, 1);
        check("t7_cnt", dct_count, 1);
        check("t7_head", itm, 38'h7C0000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
